// File: rtl/w_serial_adder_ctrl.sv
// w_serial_adder_ctrl: nibble-serial add/sub controller driving one external 4-bit adder
module w_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   Start,
   input  logic                   Sub,
   input  logic                   CarryIn,
   input  logic [4*NIBBLES-1:0]   OpA,
   input  logic [4*NIBBLES-1:0]   OpB,
   output logic [3:0]             AdderA,
   output logic [3:0]             AdderB,
   output logic                   AdderCin,
   input  logic [3:0]             AdderSum,
   input  logic                   AdderCout,
   output logic                   Busy,
   output logic                   Done,
   output logic [4*NIBBLES-1:0]   Result,
   output logic                   CarryOut,
   output logic                   Overflow
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [4*NIBBLES-1:0] a, b;
   logic sub, carry, run, last;
   logic [2:0] idx;
   assign run = state == RUN;
   assign last = idx == 3'(NIBBLES - 1);
   // adder drive: current nibble of the latched operands, B inverted for subtraction
   always_comb begin
      AdderA = run ? a[idx*4 +: 4] : 4'h0;
      AdderB = run ? b[idx*4 +: 4] ^ {4{sub}} : 4'h0;
      AdderCin = run ? carry : 1'b0;
   end
   // sequencer: latch on Start, ripple one nibble per clock, pulse Done
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
         Busy <= 1'b0;
         Done <= 1'b0;
         Result <= '0;
         CarryOut <= 1'b0;
         Overflow <= 1'b0;
         a <= '0;
         b <= '0;
         sub <= 1'b0;
         carry <= 1'b0;
         idx <= '0;
      end else begin
         case (state)
            RUN: begin
               Result[idx*4 +: 4] <= AdderSum;
               carry <= AdderCout;
               idx <= idx + 3'd1;
               if (last) begin
                  state <= DONE;
                  Busy <= 1'b0;
                  Done <= 1'b1;
                  CarryOut <= AdderCout;
                  Overflow <= (AdderA[3] == AdderB[3]) && (AdderSum[3] != AdderA[3]);
               end
            end
            default: begin
               Done <= 1'b0;
               if (Start) begin
                  a <= OpA;
                  b <= OpB;
                  sub <= Sub;
                  carry <= Sub | CarryIn;
                  idx <= '0;
                  state <= RUN;
                  Busy <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_w_serial_adder_ctrl.sv
// tb_w_serial_adder_ctrl: directed checks of the serial adder controller (NIBBLES=4 and NIBBLES=1)
module tb_w_serial_adder_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, sub = 1'b0, cin = 1'b0;
   logic [15:0] opa = '0, opb = '0, result;
   logic [3:0] aa, ab, asum;
   logic acin, acout, busy, done, cout, ovf;
   logic start1 = 1'b0, cin1 = 1'b0;
   logic [3:0] opa1 = '0, opb1 = '0, result1, aa1, ab1, asum1;
   logic acin1, acout1, busy1, done1, cout1, ovf1;
   int total = 0, bad = 0;
   logic [3:0] fb;
   logic fc;

   always #5 clk = ~clk;

   assign {acout, asum} = 5'(aa) + 5'(ab) + 5'(acin);
   assign {acout1, asum1} = 5'(aa1) + 5'(ab1) + 5'(acin1);

   w_serial_adder_ctrl #(.NIBBLES(4)) dut (
      .CLK(clk), .RST_N(rst_n), .Start(start), .Sub(sub), .CarryIn(cin),
      .OpA(opa), .OpB(opb), .AdderA(aa), .AdderB(ab), .AdderCin(acin),
      .AdderSum(asum), .AdderCout(acout), .Busy(busy), .Done(done),
      .Result(result), .CarryOut(cout), .Overflow(ovf)
   );

   w_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .Start(start1), .Sub(1'b0), .CarryIn(cin1),
      .OpA(opa1), .OpB(opb1), .AdderA(aa1), .AdderB(ab1), .AdderCin(acin1),
      .AdderSum(asum1), .AdderCout(acout1), .Busy(busy1), .Done(done1),
      .Result(result1), .CarryOut(cout1), .Overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic ci,
                     input logic [15:0] er, input logic ec, input logic ev);
      int cyc = 0, nbusy = 0;
      opa = a; opb = b; sub = s; cin = ci; start = 1'b1;
      tick();
      start = 1'b0;
      fb = ab; fc = acin;
      while (!done && cyc < 20) begin
         nbusy += int'(busy);
         tick();
         cyc++;
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " lat"}, cyc, 4);
      chk({tag, " busy"}, nbusy, 4);
      chk({tag, " res"}, result, er);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " ovf"}, ovf, ev);
      tick();
      chk({tag, " pulse"}, done, 0);
   endtask

   initial begin
      opa = 16'hBEEF; opb = 16'h1234;
      repeat (2) tick();
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst res", result, 0);
      chk("rst cout", cout, 0);
      chk("rst ovf", ovf, 0);
      chk("idle adda", aa, 0);
      chk("idle addb", ab, 0);
      rst_n = 1'b1;
      tick();
      chk("idle2 adda", aa, 0);

      op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      chk("sub cin0", fc, 1);
      chk("sub b0", fb, 4'h8);
      op("addci", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);

      // reset two cycles into a run
      opa = 16'h1111; opb = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid busy", busy, 0);
      chk("mid done", done, 0);
      chk("mid res", result, 0);
      chk("mid cout", cout, 0);
      rst_n = 1'b1;
      begin
         int nd = 0;
         for (int i = 0; i < 6; i++) begin
            nd += int'(done);
            tick();
         end
         chk("mid nodone", nd, 0);
      end

      // Start ignored while busy, then back-to-back via Done cycle
      opa = 16'h1111; opb = 16'h2222; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      opa = 16'hAAAA; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign busy3", busy, 1);
      tick();
      chk("ign done4", done, 0);
      tick();
      chk("ign done", done, 1);
      chk("ign res", result, 16'h3333);
      opa = 16'h0001; opb = 16'h0001; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b busy", busy, 1);
      chk("b2b done", done, 0);
      repeat (3) tick();
      chk("b2b run4", busy, 1);
      tick();
      chk("b2b done2", done, 1);
      chk("b2b res", result, 16'h0002);
      tick();

      // single-nibble build
      opa1 = 4'hF; opb1 = 4'h0; cin1 = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("n1 busy", busy1, 1);
      chk("n1 cin", acin1, 1);
      chk("n1 run done", done1, 0);
      tick();
      chk("n1 done", done1, 1);
      chk("n1 res", result1, 4'h0);
      chk("n1 cout", cout1, 1);
      chk("n1 ovf", ovf1, 0);
      tick();
      chk("n1 pulse", done1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
